// File: rtl/id_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, function codes,
// ALU operation/select encodings and reset/zero helpers.
package id_pipe_pkg;

   localparam logic        RST_ENABLE   = 1'b1;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [7:0] ALUOP_NOP = 8'b0000_0000;
   localparam logic [7:0] ALUOP_AND = 8'b0010_0100;
   localparam logic [7:0] ALUOP_OR  = 8'b0010_0101;
   localparam logic [7:0] ALUOP_XOR = 8'b0010_0110;
   localparam logic [7:0] ALUOP_NOR = 8'b0010_0111;
   localparam logic [7:0] ALUOP_SLL = 8'b0111_1100;
   localparam logic [7:0] ALUOP_SRL = 8'b0000_0010;
   localparam logic [7:0] ALUOP_SRA = 8'b0000_0011;

   typedef enum logic [2:0] {
      ALUSEL_NOP   = 3'b000,
      ALUSEL_LOGIC = 3'b001,
      ALUSEL_SHIFT = 3'b010
   } alusel_e;

endpackage

// File: rtl/id_pipe_if.sv
// ID/EX pipeline register bundle: the ID stage drives it (master), EX consumes it (slave).
interface id_ex_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic [7:0]        ex_aluop_o;
   logic [2:0]        ex_alusel_o;
   logic [DATA_W-1:0] ex_reg1_o;
   logic [DATA_W-1:0] ex_reg2_o;
   logic [REG_AW-1:0] ex_wd_o;
   logic              ex_wreg_o;
   logic [31:0]       ex_pc_o;
   logic              ex_valid_o;
   logic              ex_instinvalid_o;

   modport master (
      output ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o,
      output ex_wreg_o, ex_pc_o, ex_valid_o, ex_instinvalid_o
   );

   modport slave (
      input ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o,
      input ex_wreg_o, ex_pc_o, ex_valid_o, ex_instinvalid_o
   );
endinterface

// File: rtl/id_pipe_fwd_mux.sv
// One ID operand port: immediate, hardwired $0, EX/MEM bypass or regfile data.
module id_fwd_mux #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              read,
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              ex_wreg,
   input  logic [REG_AW-1:0] ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              ex_is_load,
   input  logic              mem_wreg,
   input  logic [REG_AW-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] data
);
   // A load in EX has no data yet; it is never bypassed and the stall covers it.
   always_comb begin
      data = reg_data;
      if (!read)
         data = imm;
      else if (addr == '0)
         data = '0;
      else if (ex_wreg && (ex_wd == addr) && !ex_is_load)
         data = ex_wdata;
      else if (mem_wreg && (mem_wd == addr))
         data = mem_wdata;
   end
endmodule

// File: rtl/id_pipe.sv
// Instruction decode stage: combinational decode and operand bypass feeding
// a single ID/EX register. Update priority: flush > stall hold > load-use bubble > capture.
module id_pipe
   import id_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc_i,
   input  logic [31:0]       inst_i,
   input  logic [DATA_W-1:0] reg1_data_i,
   input  logic [DATA_W-1:0] reg2_data_i,
   input  logic              ex_wreg_i,
   input  logic [REG_AW-1:0] ex_wd_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              ex_is_load_i,
   input  logic              mem_wreg_i,
   input  logic [REG_AW-1:0] mem_wd_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              reg1_read_o,
   output logic              reg2_read_o,
   output logic [REG_AW-1:0] reg1_addr_o,
   output logic [REG_AW-1:0] reg2_addr_o,
   output logic              stallreq_o,
   id_ex_if.master           ex
);
   logic [5:0]        op, fn;
   logic [7:0]        aluop;
   alusel_e           alusel;
   logic              read1, read2, wreg, instinvalid;
   logic [REG_AW-1:0] wd;
   logic [DATA_W-1:0] imm, opnd1, opnd2;

   assign op = inst_i[31:26];
   assign fn = inst_i[5:0];

   always_comb begin
      aluop       = ALUOP_NOP;
      alusel      = ALUSEL_NOP;
      read1       = 1'b0;
      read2       = 1'b0;
      wreg        = 1'b0;
      wd          = REG_AW'(NOP_REG_ADDR);
      imm         = '0;
      instinvalid = 1'b1;
      case (op)
         OP_SPECIAL: begin
            case (fn)
               FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                  read1       = 1'b1;
                  read2       = 1'b1;
                  wreg        = 1'b1;
                  wd          = REG_AW'(inst_i[15:11]);
                  alusel      = ALUSEL_LOGIC;
                  instinvalid = 1'b0;
                  aluop       = (fn == FN_AND) ? ALUOP_AND :
                                (fn == FN_OR)  ? ALUOP_OR  :
                                (fn == FN_XOR) ? ALUOP_XOR : ALUOP_NOR;
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  // Shift amount rides on port 1 as an immediate; rt is the shifted value.
                  read2       = 1'b1;
                  wreg        = 1'b1;
                  wd          = REG_AW'(inst_i[15:11]);
                  imm         = DATA_W'(inst_i[10:6]);
                  alusel      = ALUSEL_SHIFT;
                  instinvalid = 1'b0;
                  aluop       = (fn == FN_SLL) ? ALUOP_SLL :
                                (fn == FN_SRL) ? ALUOP_SRL : ALUOP_SRA;
               end
               default: ;
            endcase
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            read1       = 1'b1;
            wreg        = 1'b1;
            wd          = REG_AW'(inst_i[20:16]);
            alusel      = ALUSEL_LOGIC;
            instinvalid = 1'b0;
            aluop       = (op == OP_ANDI) ? ALUOP_AND :
                          (op == OP_XORI) ? ALUOP_XOR : ALUOP_OR;
            imm         = (op == OP_LUI) ? DATA_W'({inst_i[15:0], 16'h0000})
                                         : DATA_W'(inst_i[15:0]);
         end
         default: ;
      endcase
   end

   assign reg1_read_o = (rst == RST_ENABLE) ? 1'b0 : read1;
   assign reg2_read_o = (rst == RST_ENABLE) ? 1'b0 : read2;
   assign reg1_addr_o = (rst == RST_ENABLE) ? '0 : REG_AW'(inst_i[25:21]);
   assign reg2_addr_o = (rst == RST_ENABLE) ? '0 : REG_AW'(inst_i[20:16]);

   assign stallreq_o = ex_wreg_i & ex_is_load_i & (ex_wd_i != '0) &
                       ((reg1_read_o & (ex_wd_i == reg1_addr_o)) |
                        (reg2_read_o & (ex_wd_i == reg2_addr_o)));

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
      .read(reg1_read_o), .addr(reg1_addr_o), .imm(imm), .reg_data(reg1_data_i),
      .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
      .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i), .data(opnd1)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
      .read(reg2_read_o), .addr(reg2_addr_o), .imm(imm), .reg_data(reg2_data_i),
      .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
      .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i), .data(opnd2)
   );

   logic              load_en, bubble;
   logic [7:0]        aluop_q;
   logic [2:0]        alusel_q;
   logic [DATA_W-1:0] reg1_q, reg2_q;
   logic [REG_AW-1:0] wd_q;
   logic              wreg_q, valid_q, instinvalid_q;
   logic [31:0]       pc_q;

   // Flush overrides a held stall; a load-use hazard inserts a bubble only when not held.
   assign load_en = flush_i | ~stall_i;
   assign bubble  = flush_i | stallreq_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aluop_q       <= ALUOP_NOP;
         alusel_q      <= ALUSEL_NOP;
         reg1_q        <= '0;
         reg2_q        <= '0;
         wd_q          <= '0;
         wreg_q        <= 1'b0;
         pc_q          <= ZERO_WORD;
         valid_q       <= 1'b0;
         instinvalid_q <= 1'b0;
      end else if (load_en) begin
         aluop_q       <= bubble ? ALUOP_NOP : aluop;
         alusel_q      <= bubble ? ALUSEL_NOP : alusel;
         reg1_q        <= bubble ? '0 : opnd1;
         reg2_q        <= bubble ? '0 : opnd2;
         wd_q          <= bubble ? '0 : wd;
         wreg_q        <= bubble ? 1'b0 : wreg;
         pc_q          <= bubble ? ZERO_WORD : pc_i;
         valid_q       <= ~bubble;
         instinvalid_q <= bubble ? 1'b0 : instinvalid;
      end
   end

   assign ex.ex_aluop_o       = aluop_q;
   assign ex.ex_alusel_o      = alusel_q;
   assign ex.ex_reg1_o        = reg1_q;
   assign ex.ex_reg2_o        = reg2_q;
   assign ex.ex_wd_o          = wd_q;
   assign ex.ex_wreg_o        = wreg_q & valid_q;
   assign ex.ex_pc_o          = pc_q;
   assign ex.ex_valid_o       = valid_q;
   assign ex.ex_instinvalid_o = instinvalid_q;
endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: directed scenarios followed by random
// instruction/bypass/stall traffic compared against a behavioural model.
module tb_id_pipe;
   import id_pipe_pkg::*;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i, ex_wdata_i, mem_wdata_i;
   logic        ex_wreg_i, ex_is_load_i, mem_wreg_i, stall_i, flush_i;
   logic [4:0]  ex_wd_i, mem_wd_i;
   logic        reg1_read_o, reg2_read_o, stallreq_o;
   logic [4:0]  reg1_addr_o, reg2_addr_o;

   id_ex_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) ex_if ();

   id_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .stallreq_o(stallreq_o), .ex(ex_if)
   );

   // ---- clock / watchdog ----
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog timeout");
   end

   // ---- reference model ----
   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] pc;
      logic        valid;
      logic        inv;
   } ent_t;

   typedef struct packed {
      logic        r1, r2;
      logic [4:0]  a1, a2;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] imm;
      logic [4:0]  wd;
      logic        wreg;
      logic        inv;
   } dec_t;

   localparam int ENT_W = $bits(ent_t);
   logic [ENT_W-1:0] exp_q[$];
   ent_t model;
   int checks = 0;
   int errors = 0;

   function automatic ent_t bubble_ent();
      ent_t e;
      e = '0;
      e.aluop  = ALUOP_NOP;
      e.alusel = ALUSEL_NOP;
      return e;
   endfunction

   function automatic dec_t ref_decode(input logic [31:0] w);
      dec_t d;
      logic [5:0] op, fn;
      op = w[31:26];
      fn = w[5:0];
      d = '0;
      d.a1 = w[25:21];
      d.a2 = w[20:16];
      d.aluop = ALUOP_NOP;
      d.alusel = ALUSEL_NOP;
      d.inv = 1'b1;
      if (op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI}) begin
         d.r1 = 1'b1; d.wd = w[20:16]; d.wreg = 1'b1; d.inv = 1'b0; d.alusel = ALUSEL_LOGIC;
         d.aluop = (op == OP_ANDI) ? ALUOP_AND : (op == OP_XORI) ? ALUOP_XOR : ALUOP_OR;
         d.imm = (op == OP_LUI) ? {w[15:0], 16'h0000} : {16'h0000, w[15:0]};
      end else if (op == OP_SPECIAL && (fn inside {FN_AND, FN_OR, FN_XOR, FN_NOR})) begin
         d.r1 = 1'b1; d.r2 = 1'b1; d.wd = w[15:11]; d.wreg = 1'b1; d.inv = 1'b0;
         d.alusel = ALUSEL_LOGIC;
         case (fn)
            FN_AND:  d.aluop = ALUOP_AND;
            FN_OR:   d.aluop = ALUOP_OR;
            FN_XOR:  d.aluop = ALUOP_XOR;
            default: d.aluop = ALUOP_NOR;
         endcase
      end else if (op == OP_SPECIAL && (fn inside {FN_SLL, FN_SRL, FN_SRA})) begin
         d.r2 = 1'b1; d.wd = w[15:11]; d.wreg = 1'b1; d.inv = 1'b0;
         d.alusel = ALUSEL_SHIFT; d.imm = {27'h0, w[10:6]};
         case (fn)
            FN_SLL:  d.aluop = ALUOP_SLL;
            FN_SRL:  d.aluop = ALUOP_SRL;
            default: d.aluop = ALUOP_SRA;
         endcase
      end
      return d;
   endfunction

   function automatic logic [31:0] ref_operand(input logic rd, input logic [4:0] a,
                                               input logic [31:0] imm, input logic [31:0] rf);
      if (!rd) return imm;
      if (a == 5'd0) return 32'h0;
      if (ex_wreg_i && ex_wd_i == a && !ex_is_load_i) return ex_wdata_i;
      if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
      return rf;
   endfunction

   function automatic logic ref_stall(input dec_t d);
      return ex_wreg_i && ex_is_load_i && (ex_wd_i != 5'd0) &&
             ((d.r1 && ex_wd_i == d.a1) || (d.r2 && ex_wd_i == d.a2));
   endfunction

   function automatic ent_t observed();
      ent_t o;
      o.aluop  = ex_if.ex_aluop_o;
      o.alusel = ex_if.ex_alusel_o;
      o.reg1   = ex_if.ex_reg1_o;
      o.reg2   = ex_if.ex_reg2_o;
      o.wd     = ex_if.ex_wd_o;
      o.wreg   = ex_if.ex_wreg_o;
      o.pc     = ex_if.ex_pc_o;
      o.valid  = ex_if.ex_valid_o;
      o.inv    = ex_if.ex_instinvalid_o;
      return o;
   endfunction

   // ---- scoreboard checks ----
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_ex(input string tag, input ent_t e);
      ent_t o;
      o = observed();
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic check_comb();
      dec_t d;
      d = ref_decode(inst_i);
      if (rst) begin
         check_val("reg1_read", 32'(reg1_read_o), 32'h0);
         check_val("reg2_read", 32'(reg2_read_o), 32'h0);
         check_val("reg1_addr", 32'(reg1_addr_o), 32'h0);
         check_val("reg2_addr", 32'(reg2_addr_o), 32'h0);
         check_val("stallreq", 32'(stallreq_o), 32'h0);
      end else begin
         check_val("reg1_read", 32'(reg1_read_o), 32'(d.r1));
         check_val("reg2_read", 32'(reg2_read_o), 32'(d.r2));
         check_val("reg1_addr", 32'(reg1_addr_o), 32'(d.a1));
         check_val("reg2_addr", 32'(reg2_addr_o), 32'(d.a2));
         check_val("stallreq", 32'(stallreq_o), 32'(ref_stall(d)));
      end
   endtask

   // ---- driver tasks ----
   task automatic drive_idle();
      pc_i = '0; inst_i = '0; reg1_data_i = '0; reg2_data_i = '0;
      ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
      mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

   // Called just after a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle();
      dec_t d;
      ent_t nxt;
      #1;
      check_comb();
      d = ref_decode(inst_i);
      nxt = model;
      if (rst || flush_i) nxt = bubble_ent();
      else if (stall_i) nxt = model;
      else if (ref_stall(d)) nxt = bubble_ent();
      else begin
         nxt.aluop  = d.aluop;
         nxt.alusel = d.alusel;
         nxt.reg1   = ref_operand(d.r1, d.a1, d.imm, reg1_data_i);
         nxt.reg2   = ref_operand(d.r2, d.a2, d.imm, reg2_data_i);
         nxt.wd     = d.wd;
         nxt.wreg   = d.wreg;
         nxt.pc     = pc_i;
         nxt.valid  = 1'b1;
         nxt.inv    = d.inv;
      end
      exp_q.push_back(nxt);
      @(posedge clk);
      #1;
      model = ent_t'(exp_q.pop_front());
      check_ex("id_ex", model);
      @(negedge clk);
   endtask

   task automatic rst_pulse();
      #2 rst = 1'b1;
      #1;
      check_comb();
      check_ex("rst_async", bubble_ent());
      rst = 1'b0;
      model = bubble_ent();
   endtask

   task automatic random_inputs();
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] im;
      logic [5:0]  fn;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 7));
      sh = 5'($urandom_range(0, 31)); im = 16'($urandom);
      case ($urandom_range(0, 3))
         0: fn = FN_AND;
         1: fn = FN_OR;
         2: fn = FN_XOR;
         default: fn = FN_NOR;
      endcase
      case ($urandom_range(0, 9))
         0: inst_i = {OP_ORI, rs, rt, im};
         1: inst_i = {OP_ANDI, rs, rt, im};
         2: inst_i = {OP_XORI, rs, rt, im};
         3: inst_i = {OP_LUI, rs, rt, im};
         4: inst_i = {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
         5: inst_i = {OP_SPECIAL, rs, rt, rd, sh, (fn[0] ? FN_SRA : (fn[1] ? FN_SRL : FN_SLL))};
         6: inst_i = $urandom;
         7: inst_i = 32'h0;
         8: inst_i = {OP_SPECIAL, rs, rt, rd, 5'd0, 6'b101010};
         default: inst_i = {6'b111111, 26'($urandom)};
      endcase
      pc_i = $urandom; reg1_data_i = $urandom; reg2_data_i = $urandom;
      ex_wreg_i = 1'($urandom_range(0, 1)); ex_wd_i = 5'($urandom_range(0, 3));
      ex_wdata_i = $urandom; ex_is_load_i = ($urandom_range(0, 3) == 0);
      mem_wreg_i = 1'($urandom_range(0, 1)); mem_wd_i = 5'($urandom_range(0, 3));
      mem_wdata_i = $urandom;
      stall_i = ($urandom_range(0, 5) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
   endtask

   // ---- directed + random sequence ----
   initial begin
      ent_t held;
      rst = 1'b1;
      drive_idle();
      @(posedge clk);
      #1;
      check_comb();
      check_ex("reset", bubble_ent());
      model = bubble_ent();
      @(negedge clk);
      rst = 1'b0;

      // ORI $3,$1,0x00FF
      inst_i = {OP_ORI, 5'd1, 5'd3, 16'h00FF}; reg1_data_i = 32'h1234_0000; pc_i = 32'h100;
      cycle();
      check_val("ori_reg1", ex_if.ex_reg1_o, 32'h1234_0000);
      check_val("ori_reg2", ex_if.ex_reg2_o, 32'h0000_00FF);
      check_val("ori_wd", 32'(ex_if.ex_wd_o), 32'd3);
      check_val("ori_wreg", 32'(ex_if.ex_wreg_o), 32'd1);

      // OR $4,$1,$2: EX beats MEM on $1, then MEM supplies $2
      inst_i = {OP_SPECIAL, 5'd1, 5'd2, 5'd4, 5'd0, FN_OR};
      reg1_data_i = 32'h111; reg2_data_i = 32'h222;
      ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hA;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'hB;
      cycle();
      check_val("fwd_prio_reg1", ex_if.ex_reg1_o, 32'hA);
      mem_wd_i = 5'd2; mem_wdata_i = 32'hC;
      cycle();
      check_val("fwd_ex_reg1", ex_if.ex_reg1_o, 32'hA);
      check_val("fwd_mem_reg2", ex_if.ex_reg2_o, 32'hC);

      // load-use: EX loads $2, ID AND $5,$2,$3
      drive_idle();
      ex_wreg_i = 1'b1; ex_is_load_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'h55;
      inst_i = {OP_SPECIAL, 5'd2, 5'd3, 5'd5, 5'd0, FN_AND}; pc_i = 32'h180;
      cycle();
      check_val("lu_stallreq", 32'(stallreq_o), 32'd1);
      check_val("lu_valid", 32'(ex_if.ex_valid_o), 32'd0);
      check_val("lu_wreg", 32'(ex_if.ex_wreg_o), 32'd0);
      ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
      cycle();
      check_val("lu_capture_valid", 32'(ex_if.ex_valid_o), 32'd1);
      check_val("lu_capture_wd", 32'(ex_if.ex_wd_o), 32'd5);

      // stall hold for 3 cycles, then flush together with stall
      inst_i = {OP_ORI, 5'd0, 5'd7, 16'h1234}; pc_i = 32'h200;
      cycle();
      held = model;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inst_i = {OP_XORI, 5'd1, 5'd6, 16'($urandom)}; pc_i = 32'h204 + 32'(4 * i);
         reg1_data_i = $urandom;
         cycle();
         check_ex("stall_hold", held);
      end
      flush_i = 1'b1;
      cycle();
      check_ex("flush_over_stall", bubble_ent());
      flush_i = 1'b0; stall_i = 1'b0;

      // invalid opcode, then all-zero word as SLL $0
      inst_i = 32'hFC00_0000; pc_i = 32'h300;
      cycle();
      check_val("inv_flag", 32'(ex_if.ex_instinvalid_o), 32'd1);
      check_val("inv_wreg", 32'(ex_if.ex_wreg_o), 32'd0);
      inst_i = 32'h0;
      cycle();
      check_val("sll0_inv", 32'(ex_if.ex_instinvalid_o), 32'd0);
      check_val("sll0_wreg", 32'(ex_if.ex_wreg_o), 32'd1);

      // $0 read while EX writes $0; then EX load to $0 must not stall
      inst_i = {OP_SPECIAL, 5'd0, 5'd1, 5'd6, 5'd0, FN_OR}; reg1_data_i = 32'h777;
      ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'hDEAD;
      cycle();
      check_val("zero_reg_operand", ex_if.ex_reg1_o, 32'h0);
      ex_is_load_i = 1'b1;
      cycle();
      check_val("zero_load_nostall", 32'(ex_if.ex_valid_o), 32'd1);
      drive_idle();

      // asynchronous reset between edges mid-operation
      inst_i = {OP_ORI, 5'd1, 5'd2, 16'hBEEF}; reg1_data_i = 32'h4444; pc_i = 32'h400;
      cycle();
      inst_i = {OP_ANDI, 5'd2, 5'd3, 16'h0F0F}; pc_i = 32'h404;
      rst_pulse();
      cycle();

      // reset during a stall drops the held entry; next edge captures
      stall_i = 1'b1; inst_i = {OP_LUI, 5'd0, 5'd9, 16'hCAFE}; pc_i = 32'h500;
      cycle();
      rst_pulse();
      stall_i = 1'b0;
      cycle();
      check_val("post_rst_capture", 32'(ex_if.ex_valid_o), 32'd1);
      check_val("post_rst_lui", ex_if.ex_reg2_o, 32'hCAFE_0000);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         random_inputs();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
